pointcounter_fsm: RTL and testbench

- Parametrised game score controller for the point-counter subsystem.
- Tracks per-player scores in BCD for direct 7-segment display and enforces a post-point lockout window.
- Detects the winning condition, with an optional win-by-two mode, and sequences IDLE/PLAY/HOLD/WIN.
- Sits between the debounced button/sensor pulse logic (upstream) and the display mux (downstream).

---
 rtl/pointcounter_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_pointcounter_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pointcounter_fsm.sv
// pointcounter_fsm
//   Game score controller. Keeps one BCD score per player for direct display,
//   mirrors each score in a binary shadow counter for the lead comparison,
//   enforces a lockout (HOLD) after every accepted point and detects the win.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   start      1-cycle pulse, begins (or restarts) a game with zeroed scores
//   clear      1-cycle pulse, abort to IDLE with zeroed scores
//   point      1-cycle pulses, bit i = point for player i
//   score      BCD scores, player i at [i*DIGITS*4 +: DIGITS*4], LS digit lowest
//   state      00 IDLE, 01 PLAY, 10 HOLD, 11 WIN
//   winner     one-hot winning player, 0 unless in WIN
//   point_ack  1-cycle pulse, the cycle after a point was accepted
//   collision  1-cycle pulse, the cycle after >1 point bit was seen in PLAY
//
// Interface semantics: there is no valid/ready backpressure. Every input is a
// single-cycle pulse sampled on one rising edge; an input that is not acted on
// in that cycle is dropped. Precedence on a given edge is rst, clear, start,
// point. Every output is a register.

module pointcounter_fsm #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2,
  parameter int WIN_SCORE   = 11,
  parameter int WIN_BY_TWO  = 0,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            clear,
  input  logic [NUM_PLAYERS-1:0]          point,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score,
  output logic [1:0]                      state,
  output logic [NUM_PLAYERS-1:0]          winner,
  output logic                            point_ack,
  output logic                            collision
);

  localparam int SW        = DIGITS * 4;
  localparam int MAX_SCORE = 10**DIGITS - 1;
  localparam int CW        = $clog2(MAX_SCORE + 1);
  localparam int PW        = $clog2(NUM_PLAYERS);
  localparam int HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HOLD_LD_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  localparam logic [CW-1:0] MAX_BIN = CW'(MAX_SCORE);
  localparam logic [CW-1:0] WIN_BIN = CW'(WIN_SCORE);
  localparam logic [CW:0]   TWO     = (CW+1)'(2);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_LD_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_HOLD = 2'b10,
    ST_WIN  = 2'b11
  } state_e;

  state_e                            state_q, state_d;
  logic [NUM_PLAYERS*SW-1:0]         score_q, score_d;
  logic [CW-1:0]                     bin_q [NUM_PLAYERS];
  logic [CW-1:0]                     bin_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]            winner_q, winner_d;
  logic [HW-1:0]                     hold_q, hold_d;
  logic                              ack_q, ack_d;
  logic                              coll_q, coll_d;

  logic                              multi_hit, single_hit;
  logic [PW-1:0]                     p_idx;
  logic [SW-1:0]                     cur_bcd, new_bcd;
  logic [CW-1:0]                     cur_bin, new_bin;
  logic                              lead_ok, win_hit;

  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // x & (x-1) clears the lowest set bit: nonzero means two or more bits set.
  assign multi_hit  = (point & (point - 1'b1)) != '0;
  assign single_hit = (point != '0) && !multi_hit;

  always_comb begin
    p_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (point[i]) p_idx = PW'(i);
    end
  end

  // Saturation is decided on the binary shadow so BCD and binary stay in step.
  assign cur_bcd = score_q[p_idx*SW +: SW];
  assign cur_bin = bin_q[p_idx];
  assign new_bcd = (cur_bin == MAX_BIN) ? cur_bcd : bcd_inc(cur_bcd);
  assign new_bin = (cur_bin == MAX_BIN) ? cur_bin : cur_bin + 1'b1;

  // Compare against other players' current scores; only the scorer changes
  // this cycle because a single point bit is required.
  always_comb begin
    lead_ok = 1'b1;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if ((PW'(j) != p_idx) && ({1'b0, new_bin} < ({1'b0, bin_q[j]} + TWO))) begin
        lead_ok = 1'b0;
      end
    end
  end

  assign win_hit = (new_bin >= WIN_BIN) &&
                   ((WIN_BY_TWO == 0) || (new_bin == MAX_BIN) || lead_ok);

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    bin_d    = bin_q;
    winner_d = winner_q;
    hold_d   = hold_q;
    ack_d    = 1'b0;
    coll_d   = 1'b0;
    if (clear) begin
      state_d  = ST_IDLE;
      score_d  = '0;
      winner_d = '0;
      hold_d   = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) bin_d[i] = '0;
    end else if (start) begin
      state_d  = ST_PLAY;
      score_d  = '0;
      winner_d = '0;
      hold_d   = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) bin_d[i] = '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (multi_hit) begin
            coll_d = 1'b1;
          end else if (single_hit) begin
            ack_d                    = 1'b1;
            score_d[p_idx*SW +: SW]  = new_bcd;
            bin_d[p_idx]             = new_bin;
            if (win_hit) begin
              state_d  = ST_WIN;
              winner_d = point;  // already one-hot
            end else if (HOLD_CYCLES > 0) begin
              state_d = ST_HOLD;
              hold_d  = HOLD_LD;
            end
          end
        end
        // Counter loaded with HOLD_CYCLES-1 on entry, so HOLD lasts exactly
        // HOLD_CYCLES cycles.
        ST_HOLD: begin
          if (hold_q == '0) state_d = ST_PLAY;
          else              hold_d  = hold_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      score_q  <= '0;
      winner_q <= '0;
      hold_q   <= '0;
      ack_q    <= 1'b0;
      coll_q   <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) bin_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      winner_q <= winner_d;
      hold_q   <= hold_d;
      ack_q    <= ack_d;
      coll_q   <= coll_d;
      bin_q    <= bin_d;
    end
  end

  assign score     = score_q;
  assign state     = state_q;
  assign winner    = winner_q;
  assign point_ack = ack_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_pointcounter_fsm.sv
// Bench for pointcounter_fsm. Three instances:
//   u0: defaults (2 players, 2 digits, win at 11, no win-by-two, hold 4)
//   u1: win-by-two enabled, otherwise defaults
//   u2: 1 digit, win at 9, win-by-two, no hold state
// Inputs are driven and outputs sampled on the falling edge.

module tb_pointcounter_fsm;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_WIN  = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start0, clear0, start1, clear1, start2, clear2;
  logic [1:0]  point0, point1, point2;
  logic [15:0] score0, score1;
  logic [7:0]  score2;
  logic [1:0]  state0, state1, state2;
  logic [1:0]  winner0, winner1, winner2;
  logic        ack0, ack1, ack2, coll0, coll1, coll2;

  pointcounter_fsm u0 (
    .clk(clk), .rst(rst), .start(start0), .clear(clear0), .point(point0),
    .score(score0), .state(state0), .winner(winner0),
    .point_ack(ack0), .collision(coll0)
  );

  pointcounter_fsm #(.WIN_BY_TWO(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .clear(clear1), .point(point1),
    .score(score1), .state(state1), .winner(winner1),
    .point_ack(ack1), .collision(coll1)
  );

  pointcounter_fsm #(.DIGITS(1), .WIN_SCORE(9), .WIN_BY_TWO(1), .HOLD_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .clear(clear2), .point(point2),
    .score(score2), .state(state2), .winner(winner2),
    .point_ack(ack2), .collision(coll2)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] get_score(input int k);
    case (k)
      0:       return score0;
      1:       return score1;
      default: return {8'h00, score2};
    endcase
  endfunction

  function automatic logic [6:0] get_flags(input int k);
    // {state, winner, ack, collision, 1'b0}
    case (k)
      0:       return {state0, winner0, ack0, coll0, 1'b0};
      1:       return {state1, winner1, ack1, coll1, 1'b0};
      default: return {state2, winner2, ack2, coll2, 1'b0};
    endcase
  endfunction

  task automatic check_all(input int k, input string tag, input logic [1:0] st,
                           input logic [15:0] sc, input logic [1:0] wn,
                           input logic ak, input logic cl);
    logic [6:0] f;
    f = get_flags(k);
    check_eq({tag, ".state"},     f[6:5], st);
    check_eq({tag, ".score"},     get_score(k), sc);
    check_eq({tag, ".winner"},    f[4:3], wn);
    check_eq({tag, ".point_ack"}, f[2], ak);
    check_eq({tag, ".collision"}, f[1], cl);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input int k, input logic s, input logic c, input logic [1:0] p);
    case (k)
      0:       begin start0 = s; clear0 = c; point0 = p; end
      1:       begin start1 = s; clear1 = c; point1 = p; end
      default: begin start2 = s; clear2 = c; point2 = p; end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present inputs for exactly one rising edge, return at the following
  // falling edge with inputs back at zero.
  task automatic drive(input int k, input logic s, input logic c, input logic [1:0] p);
    set_in(k, s, c, p);
    tick();
    set_in(k, 1'b0, 1'b0, 2'b00);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 3; k++) set_in(k, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) check_all(k, $sformatf("reset%0d", k), S_IDLE, 16'h0, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;

    // ---- u0: IDLE ignores points, then start ----
    drive(0, 1'b0, 1'b0, 2'b01);
    check_all(0, "idle_point", S_IDLE, 16'h0000, 2'b00, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 2'b00);
    check_all(0, "start", S_PLAY, 16'h0000, 2'b00, 1'b0, 1'b0);

    // ---- u0: first point, hold window, point during hold ignored ----
    drive(0, 1'b0, 1'b0, 2'b01);
    check_all(0, "p0_first", S_HOLD, 16'h0001, 2'b00, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0, 2'b01);
    check_all(0, "hold_ignore", S_HOLD, 16'h0001, 2'b00, 1'b0, 1'b0);
    tick();
    check_eq("hold_c3.state", state0, S_HOLD);
    tick();
    check_eq("hold_c4.state", state0, S_HOLD);
    tick();
    check_eq("hold_end.state", state0, S_PLAY);

    // ---- u0: collision in PLAY, then none during HOLD ----
    drive(0, 1'b0, 1'b0, 2'b11);
    check_all(0, "coll_play", S_PLAY, 16'h0001, 2'b00, 1'b0, 1'b1);
    tick();
    check_eq("coll_pulse_end", coll0, 1'b0);
    drive(0, 1'b0, 1'b0, 2'b01);
    check_all(0, "p0_second", S_HOLD, 16'h0002, 2'b00, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0, 2'b11);
    check_all(0, "coll_hold", S_HOLD, 16'h0002, 2'b00, 1'b0, 1'b0);
    repeat (3) tick();
    check_eq("hold2_end.state", state0, S_PLAY);

    // ---- u0: 11 spaced points to P1, BCD carry and win ----
    for (int i = 1; i <= 11; i++) exp_q.push_back({to_bcd(i), 8'h02});
    for (int i = 1; i <= 11; i++) begin
      logic [15:0] e;
      drive(0, 1'b0, 1'b0, 2'b10);
      e = exp_q.pop_front();
      check_eq($sformatf("p1_run%0d.score", i), score0, e);
      if (i < 11) begin
        check_eq($sformatf("p1_run%0d.state", i), state0, S_HOLD);
        repeat (4) tick();
      end
    end
    check_all(0, "p1_win", S_WIN, 16'h1102, 2'b10, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0, 2'b10);
    check_all(0, "win_frozen", S_WIN, 16'h1102, 2'b10, 1'b0, 1'b0);
    tick();
    check_all(0, "win_held", S_WIN, 16'h1102, 2'b10, 1'b0, 1'b0);

    // ---- u0: restart from WIN, then clear+start+point mid-game ----
    drive(0, 1'b1, 1'b0, 2'b00);
    check_all(0, "restart", S_PLAY, 16'h0000, 2'b00, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 2'b01);
    check_eq("pre_clear.score", score0, 16'h0001);
    repeat (4) tick();
    drive(0, 1'b1, 1'b1, 2'b01);
    check_all(0, "clear_mid", S_IDLE, 16'h0000, 2'b00, 1'b0, 1'b0);
    tick();
    check_eq("clear_stays.state", state0, S_IDLE);

    // ---- u1: win-by-two, drive to 10-10 ----
    drive(1, 1'b1, 1'b0, 2'b00);
    check_eq("wb2_start.state", state1, S_PLAY);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1'b0, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
      repeat (4) tick();
    end
    check_all(1, "wb2_tie", S_PLAY, 16'h1010, 2'b00, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 2'b01);
    check_all(1, "wb2_lead1", S_HOLD, 16'h1011, 2'b00, 1'b1, 1'b0);
    repeat (4) tick();
    check_eq("wb2_back.state", state1, S_PLAY);
    drive(1, 1'b0, 1'b0, 2'b01);
    check_all(1, "wb2_win", S_WIN, 16'h1012, 2'b01, 1'b1, 1'b0);

    // ---- u2: 1 digit, no hold, saturating win at 9 with lead 1 ----
    drive(2, 1'b1, 1'b0, 2'b00);
    check_eq("d1_start.state", state2, S_PLAY);
    drive(2, 1'b0, 1'b0, 2'b01);
    check_all(2, "d1_first", S_PLAY, 16'h0001, 2'b00, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) drive(2, 1'b0, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
    check_all(2, "d1_tie", S_PLAY, 16'h0088, 2'b00, 1'b1, 1'b0);
    drive(2, 1'b0, 1'b0, 2'b01);
    check_all(2, "d1_win", S_WIN, 16'h0089, 2'b01, 1'b1, 1'b0);
    drive(2, 1'b0, 1'b0, 2'b01);
    check_all(2, "d1_sat", S_WIN, 16'h0089, 2'b01, 1'b0, 1'b0);

    // ---- u0: reset mid-game with start+point asserted ----
    drive(0, 1'b1, 1'b0, 2'b00);
    drive(0, 1'b0, 1'b0, 2'b01);
    check_eq("pre_rst.score", score0, 16'h0001);
    repeat (4) tick();
    rst = 1'b1;
    set_in(0, 1'b1, 1'b0, 2'b01);
    tick();
    check_all(0, "rst_mid", S_IDLE, 16'h0000, 2'b00, 1'b0, 1'b0);
    set_in(0, 1'b0, 1'b0, 2'b00);
    rst = 1'b0;

    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
